// File: rtl/ajuste_hora_ctrl.sv
// Time-set controller: button presses -> field select, up/down pulses with auto-repeat, 12/24 h flag.
// Define BLINK_EN to build the edit-mode blink generator; otherwise blink is held high.
module ajuste_hora_ctrl #(
    parameter int NFIELD     = 3,
    parameter int CNT_W      = 30,
    parameter int RPT_START  = 50000000,
    parameter int RPT_PERIOD = 10000000,
    parameter int TIMEOUT    = 1000000000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_fmt,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       formato_hora,
    output logic       edit_active,
    output logic       blink
);

    typedef enum logic [1:0] {S_RUN, S_EDIT, S_HOLD, S_REPEAT} state_t;

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(RPT_START - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_FIELD   = 4'(NFIELD);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             dir_up;
    logic             mode_q;
    logic             up_q;
    logic             down_q;
    logic             fmt_q;
    logic             press_mode;
    logic             press_up;
    logic             press_down;
    logic             press_fmt;
    logic             dir_held;
    logic             pulse_busy;
    logic             fire_up;
    logic             fire_down;
    logic             timed_out;

    assign press_mode = btn_mode & ~mode_q;
    assign press_up   = btn_up & ~up_q;
    assign press_down = btn_down & ~down_q;
    assign press_fmt  = btn_fmt & ~fmt_q;
    assign dir_held   = dir_up ? btn_up : btn_down;
    assign pulse_busy = enUP | enDOWN;

    // Pulse and timeout decisions; a mode press always wins and suppresses any pulse.
    always_comb begin
        fire_up   = 1'b0;
        fire_down = 1'b0;
        timed_out = 1'b0;
        case (state)
            S_EDIT: begin
                if (!press_mode) begin
                    fire_up   = press_up & ~press_down;
                    fire_down = press_down & ~press_up;
                    timed_out = ~press_up & ~press_down & (timer >= TIMEOUT_LAST);
                end
            end
            S_HOLD: begin
                if (!press_mode && dir_held && !pulse_busy && (timer >= START_LAST)) begin
                    fire_up   = dir_up;
                    fire_down = ~dir_up;
                end
            end
            S_REPEAT: begin
                if (!press_mode && dir_held && !pulse_busy && (timer >= PERIOD_LAST)) begin
                    fire_up   = dir_up;
                    fire_down = ~dir_up;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_RUN;
            timer        <= '0;
            dir_up       <= 1'b0;
            mode_q       <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            fmt_q        <= 1'b0;
            en_count     <= 4'd0;
            enUP         <= 1'b0;
            enDOWN       <= 1'b0;
            formato_hora <= 1'b0;
            edit_active  <= 1'b0;
        end else begin
            mode_q <= btn_mode;
            up_q   <= btn_up;
            down_q <= btn_down;
            fmt_q  <= btn_fmt;
            enUP   <= fire_up;
            enDOWN <= fire_down;
            if (press_fmt) begin
                formato_hora <= ~formato_hora;
            end
            case (state)
                S_RUN: begin
                    if (press_mode) begin
                        state       <= S_EDIT;
                        en_count    <= 4'd1;
                        edit_active <= 1'b1;
                        timer       <= '0;
                    end
                end
                S_EDIT: begin
                    if (press_mode) begin
                        timer <= '0;
                        if (en_count >= LAST_FIELD) begin
                            state       <= S_RUN;
                            en_count    <= 4'd0;
                            edit_active <= 1'b0;
                        end else begin
                            en_count    <= en_count + 4'd1;
                            edit_active <= 1'b1;
                        end
                    end else if (fire_up || fire_down) begin
                        state  <= S_HOLD;
                        dir_up <= fire_up;
                        timer  <= '0;
                    end else if (press_up || press_down) begin
                        timer <= '0;
                    end else if (timed_out) begin
                        state       <= S_RUN;
                        en_count    <= 4'd0;
                        edit_active <= 1'b0;
                        timer       <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                // S_HOLD and S_REPEAT share everything except the threshold used above.
                default: begin
                    if (press_mode) begin
                        timer <= '0;
                        if (en_count >= LAST_FIELD) begin
                            state       <= S_RUN;
                            en_count    <= 4'd0;
                            edit_active <= 1'b0;
                        end else begin
                            state       <= S_EDIT;
                            en_count    <= en_count + 4'd1;
                            edit_active <= 1'b1;
                        end
                    end else if (!dir_held) begin
                        state <= S_EDIT;
                        timer <= '0;
                    end else if (fire_up || fire_down) begin
                        state <= S_REPEAT;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + CNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             field_chg;

    assign field_chg = press_mode | timed_out;

    // Any pulse or field change shows the digits solid and restarts the half-period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (field_chg || fire_up || fire_down || !edit_active) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt >= BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end
`else
    // Constant high; BLINK_HALF only matters when the blink generator is built in.
    assign blink = (BLINK_HALF > 0) | 1'b1;
`endif

endmodule

// File: tb/tb_ajuste_hora_ctrl.sv
// Directed bench for ajuste_hora_ctrl with shortened timing (RPT_START=8, RPT_PERIOD=4, TIMEOUT=32).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_ajuste_hora_ctrl;

    localparam int NFIELD     = 3;
    localparam int CNT_W      = 30;
    localparam int RPT_START  = 8;
    localparam int RPT_PERIOD = 4;
    localparam int TIMEOUT    = 32;
    localparam int BLINK_HALF = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       btn_fmt;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       formato_hora;
    logic       edit_active;
    logic       blink;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ajuste_hora_ctrl #(
        .NFIELD    (NFIELD),
        .CNT_W     (CNT_W),
        .RPT_START (RPT_START),
        .RPT_PERIOD(RPT_PERIOD),
        .TIMEOUT   (TIMEOUT),
        .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_fmt     (btn_fmt),
        .en_count    (en_count),
        .enUP        (enUP),
        .enDOWN      (enDOWN),
        .formato_hora(formato_hora),
        .edit_active (edit_active),
        .blink       (blink)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tap_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        tick();
    endtask

    // Cycle k after the press edge: first pulse at 1, first repeat at 1+8, then every 4.
    function automatic logic repeat_pulse(int rel);
        return (rel == 1) || (rel >= 9 && rel <= 25 && ((rel - 9) % 4) == 0);
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        btn_fmt  = 1'b1;
        repeat (3) tick();
        checks++;
        if (en_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_en_count: got %0d, expected 0", en_count);
        end
        checks++;
        if (enUP !== 1'b0 || enDOWN !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_pulses: got enUP=%b enDOWN=%b, expected 0 0", enUP, enDOWN);
        end
        checks++;
        if (formato_hora !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_formato: got %b, expected 0", formato_hora);
        end
        checks++;
        if (edit_active !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_edit_active: got %b, expected 0", edit_active);
        end
        checks++;
        if (blink !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_blink: got %b, expected 1", blink);
        end
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_fmt  = 1'b0;
        reset    = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (enUP !== 1'b0 || enDOWN !== 1'b0 || en_count !== 4'd0 || formato_hora !== 1'b0) begin
                fails++;
                $display("[TB] FAIL post_reset cycle %0d: got enUP=%b enDOWN=%b en_count=%0d fmt=%b, expected 0 0 0 0",
                         i, enUP, enDOWN, en_count, formato_hora);
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [3:0] exp_seq [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            btn_mode = 1'b1;
            tick();
            checks++;
            if (en_count !== exp_seq[i] || edit_active !== (exp_seq[i] != 4'd0)) begin
                fails++;
                $display("[TB] FAIL mode_step %0d: got en_count=%0d edit_active=%b, expected %0d %b",
                         i, en_count, edit_active, exp_seq[i], exp_seq[i] != 4'd0);
            end
            btn_mode = 1'b0;
            tick();
        end
    endtask

    task automatic test_tap();
        int n_up;
        int n_dn;
        repeat (3) tap_mode();
        checks++;
        if (en_count !== 4'd3) begin
            fails++;
            $display("[TB] FAIL tap_field: got %0d, expected 3", en_count);
        end
        // Pattern 0: up only, 1: down only, 2: both together.
        for (int p = 0; p < 3; p++) begin
            n_up = 0;
            n_dn = 0;
            for (int i = 0; i < 6; i++) begin
                btn_up   = (i < 2) && (p != 1);
                btn_down = (i < 2) && (p != 0);
                tick();
                n_up += int'(enUP);
                n_dn += int'(enDOWN);
            end
            checks++;
            if (n_up != ((p == 0) ? 1 : 0) || n_dn != ((p == 1) ? 1 : 0)) begin
                fails++;
                $display("[TB] FAIL tap_pattern %0d: got up=%0d down=%0d pulses, expected %0d %0d",
                         p, n_up, n_dn, (p == 0) ? 1 : 0, (p == 1) ? 1 : 0);
            end
        end
        checks++;
        if (en_count !== 4'd3) begin
            fails++;
            $display("[TB] FAIL tap_field_kept: got %0d, expected 3", en_count);
        end
    endtask

    task automatic test_hold_repeat();
        int n_up = 0;
        repeat (3) tap_mode();
        checks++;
        if (en_count !== 4'd2) begin
            fails++;
            $display("[TB] FAIL hold_field: got %0d, expected 2", en_count);
        end
        for (int rel = 1; rel <= 35; rel++) begin
            btn_up = (rel <= 25);
            tick();
            n_up += int'(enUP);
            checks++;
            if (enUP !== repeat_pulse(rel) || enDOWN !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hold_pulse cycle %0d: got enUP=%b enDOWN=%b, expected enUP=%b enDOWN=0",
                         rel, enUP, enDOWN, repeat_pulse(rel));
            end
        end
        btn_up = 1'b0;
        checks++;
        if (n_up != 6) begin
            fails++;
            $display("[TB] FAIL hold_count: got %0d pulses, expected 6", n_up);
        end
    endtask

    task automatic test_timeout();
        logic stayed;
        int   n_dn = 0;
        tap_mode();
        tap_mode();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        checks++;
        if (en_count !== 4'd1) begin
            fails++;
            $display("[TB] FAIL timeout_entry: got %0d, expected 1", en_count);
        end
        stayed = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (en_count !== 4'd1) stayed = 1'b0;
        end
        checks++;
        if (stayed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL timeout_early: got early exit, expected field 1 for 31 cycles");
        end
        tick();
        checks++;
        if (en_count !== 4'd0 || edit_active !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_exit: got en_count=%0d edit_active=%b, expected 0 0", en_count, edit_active);
        end
        // Long hold must not time out; the idle count restarts at release.
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 40; i++) begin
            btn_down = 1'b1;
            tick();
            n_dn += int'(enDOWN);
            if (en_count !== 4'd1) stayed = 1'b0;
        end
        btn_down = 1'b0;
        checks++;
        if (stayed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL hold_no_timeout: got field change during hold, expected field 1");
        end
        checks++;
        if (n_dn != 9) begin
            fails++;
            $display("[TB] FAIL hold_down_count: got %0d pulses, expected 9", n_dn);
        end
        tick();
        stayed = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (en_count !== 4'd1) stayed = 1'b0;
        end
        checks++;
        if (stayed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL release_timeout_early: got early exit, expected field 1 for 31 cycles");
        end
        tick();
        checks++;
        if (en_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL release_timeout_exit: got %0d, expected 0", en_count);
        end
    endtask

    task automatic test_format();
        int n_up = 0;
        btn_fmt = 1'b1;
        tick();
        checks++;
        if (formato_hora !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fmt_toggle_run: got %b, expected 1", formato_hora);
        end
        tick();
        tick();
        btn_fmt = 1'b0;
        tick();
        checks++;
        if (formato_hora !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fmt_single_toggle: got %b, expected 1", formato_hora);
        end
        tap_mode();
        for (int rel = 1; rel <= 30; rel++) begin
            btn_up  = (rel <= 25);
            btn_fmt = (rel == 14);
            tick();
            n_up += int'(enUP);
            if (rel == 14) begin
                checks++;
                if (formato_hora !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL fmt_toggle_repeat: got %b, expected 0", formato_hora);
                end
            end
            checks++;
            if (enUP !== repeat_pulse(rel)) begin
                fails++;
                $display("[TB] FAIL fmt_repeat_pulse cycle %0d: got %b, expected %b", rel, enUP, repeat_pulse(rel));
            end
        end
        btn_up  = 1'b0;
        btn_fmt = 1'b0;
        checks++;
        if (n_up != 6 || formato_hora !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fmt_repeat_total: got %0d pulses fmt=%b, expected 6 0", n_up, formato_hora);
        end
    endtask

    task automatic test_mode_abort();
        int n_up = 0;
        for (int rel = 1; rel <= 20; rel++) begin
            btn_up   = 1'b1;
            btn_mode = (rel == 4);
            tick();
            n_up += int'(enUP);
        end
        btn_up   = 1'b0;
        btn_mode = 1'b0;
        checks++;
        if (n_up != 1 || en_count !== 4'd2) begin
            fails++;
            $display("[TB] FAIL mode_abort: got %0d pulses en_count=%0d, expected 1 2", n_up, en_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 10; i++) begin
            btn_up = 1'b1;
            tick();
        end
        reset = 1'b0;
        tick();
        checks++;
        if (enUP !== 1'b0 || en_count !== 4'd0 || edit_active !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_hold_cycle: got enUP=%b en_count=%0d edit=%b, expected 0 0 0",
                     enUP, en_count, edit_active);
        end
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (enUP !== 1'b0 || en_count !== 4'd0) begin
                fails++;
                $display("[TB] FAIL reset_hold_after %0d: got enUP=%b en_count=%0d, expected 0 0", i, enUP, en_count);
            end
        end
        btn_up = 1'b0;
        tick();
    endtask

    task automatic test_blink();
        logic exp_blink;
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        checks++;
        if (blink !== 1'b1) begin
            fails++;
            $display("[TB] FAIL blink_entry: got %b, expected 1", blink);
        end
`ifdef BLINK_EN
        for (int k = 1; k <= 10; k++) begin
            btn_up = (k == 6);
            tick();
            exp_blink = (k < 4) || (k >= 6 && k < 10);
            checks++;
            if (blink !== exp_blink) begin
                fails++;
                $display("[TB] FAIL blink_cycle %0d: got %b, expected %b", k, blink, exp_blink);
            end
        end
`else
        for (int k = 1; k <= 10; k++) begin
            btn_up = (k == 6);
            tick();
            exp_blink = 1'b1;
            checks++;
            if (blink !== exp_blink) begin
                fails++;
                $display("[TB] FAIL blink_const cycle %0d: got %b, expected 1", k, blink);
            end
        end
`endif
        btn_up = 1'b0;
        repeat (3) tap_mode();
        checks++;
        if (blink !== 1'b1 || en_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL blink_run: got blink=%b en_count=%0d, expected 1 0", blink, en_count);
        end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_tap();
        test_hold_repeat();
        test_timeout();
        test_format();
        test_mode_abort();
        test_reset_mid_hold();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ajuste_hora_ctrl.md
Name: ajuste_hora_ctrl

Overview:
- Time-set controller for the real-time-clock datapath.
- Turns debounced push-button levels into the field-select code en_count[3:0] and single-cycle enUP/enDOWN pulses consumed by the seconds/minutes/hours counters (field code 3 = hours).
- Owns the 12/24 h format flag (formato_hora) and returns to run mode after an inactivity timeout.
- Provides auto-repeat on held up/down buttons.

Parameters:
- NFIELD, 3, number of editable fields; field codes 1..NFIELD.
- CNT_W, 30, width of the shared hold/repeat/timeout timer.
- RPT_START, 50000000, cycles from the first pulse to the first auto-repeat pulse.
- RPT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses.
- TIMEOUT, 1000000000, idle cycles in edit mode before returning to run.
- BLINK_HALF, 25000000, half-period of the blink output (only with BLINK_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- btn_mode  input  1  debounced level; advance field.
- btn_up  input  1  debounced level; increment selected field.
- btn_down  input  1  debounced level; decrement selected field.
- btn_fmt  input  1  debounced level; toggle 12/24 h format.
- en_count  output  4  selected field; 0 = run, no field selected.
- enUP  output  1  one-cycle increment pulse.
- enDOWN  output  1  one-cycle decrement pulse.
- formato_hora  output  1  1 = 12 h, 0 = 24 h.
- edit_active  output  1  high while en_count != 0.
- blink  output  1  display blank/flash control.

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) forces:
  - en_count=0, enUP=0, enDOWN=0, formato_hora=0, edit_active=0, blink=1.
  - FSM to S_RUN, timer=0, button history registers=0.
- Edge detect: each button is registered once. Press = current sample 1 and previous sample 0.
- Output latency: an output reacts in the clock after the edge at which the press is detected.
- enUP/enDOWN are never high on two consecutive cycles. Downstream edge detectors therefore see a fresh rising edge on every pulse.
- S_RUN:
  - en_count=0; up/down presses ignored.
  - mode press -> S_EDIT with en_count=1, timer=0.
- S_EDIT:
  - en_count=current field.
  - mode press: field+1, or S_RUN (en_count=0) if field==NFIELD. Timer cleared.
  - up press alone: enUP pulse, timer=0, -> S_HOLD (dir=up). Down press alone behaves the same with enDOWN.
  - up and down pressed in the same cycle: ignored, no pulse. Timer is still cleared.
  - No press for TIMEOUT consecutive cycles: -> S_RUN, en_count=0.
- S_HOLD:
  - Timer counts while the dir button stays high.
  - On reaching RPT_START: one pulse in dir, timer=0, -> S_REPEAT.
  - Release -> S_EDIT, timer=0.
- S_REPEAT:
  - Pulse every RPT_PERIOD cycles while held.
  - Release -> S_EDIT, timer=0.
- Hold/repeat interactions:
  - Opposite button pressing in S_HOLD or S_REPEAT is ignored.
  - A mode press aborts the hold, advances the field exactly as in S_EDIT and suppresses further pulses. The next pulse requires a new press.
- Timeout counting: TIMEOUT is counted only in S_EDIT. Time spent holding never times out.
- btn_fmt press: toggles formato_hora in any state, independent of the FSM, one toggle per press.
- edit_active = (en_count != 0), registered alongside en_count.
- Timer saturates; it never wraps.
- Reset mid-hold: no pulse is emitted in the reset cycle or the cycle after it.

Optional Feature:
- Macro BLINK_EN.
- Defined:
  - A BLINK_HALF counter toggles blink while edit_active.
  - blink is forced to 1 on any pulse or field change, and the blink counter restarts.
  - blink=1 in S_RUN.
- Undefined:
  - blink is tied to 1 and no blink counter is synthesized.
  - BLINK_HALF is unused.

Test Plan (bench params NFIELD=3, RPT_START=8, RPT_PERIOD=4, TIMEOUT=32, BLINK_HALF=4):
- Reset low 3 cycles with all buttons high, then release -> en_count=0, formato_hora=0, enUP=enDOWN=0. No pulse in the first 2 cycles after release.
- Four mode presses from S_RUN -> en_count sequence 1, 2, 3, 0. edit_active=1 only for codes 1..3.
- In field 3, tap up for 2 cycles -> exactly one enUP pulse. Tap down -> exactly one enDOWN pulse. Up and down in the same cycle -> no pulse.
- In field 2, hold up for 25 cycles after the press -> enUP pulses at relative cycles 1, 9, 13, 17, 21, 25 (6 pulses), each 1 cycle wide. Release -> no further pulses.
- Enter field 1 and apply no presses for 32 cycles -> en_count returns to 0. Holding down for 40 cycles causes no timeout, then a timeout follows 32 cycles after release.
- Press btn_fmt in S_RUN, then in S_REPEAT -> formato_hora toggles 0 -> 1 -> 0 and repeat pulses continue uninterrupted.
- With BLINK_EN in field 1 -> blink toggles every 4 cycles. An up pulse forces blink=1 and restarts the count.
